// File: rtl/pipelined_divider_valrdy_pkg.sv
// divider_pkg: shared flag type and sizing helper for the pipelined divider
package divider_pkg;
  typedef struct packed {
    logic neg_q;
    logic neg_r;
    logic dz;
  } div_flags_t;
  function automatic int div_iters(input int width, input int stages);
    return width / stages;
  endfunction
endpackage

// File: rtl/pipelined_divider_valrdy_stage.sv
// divider_stage: ITERS restoring-division iterations, resolving this stage's quotient bits MSB first
module divider_stage #(
  parameter int WIDTH = 32,
  parameter int ITERS = 4,
  parameter int STAGE_IDX = 0
) (
  input  logic [ITERS-1:0] i_bits,
  input  logic [WIDTH-1:0] i_divisor,
  input  logic [WIDTH-1:0] i_quot,
  input  logic [WIDTH:0]   i_rem,
  output logic [WIDTH-1:0] o_quot,
  output logic [WIDTH:0]   o_rem
);
  localparam int MSB = WIDTH - 1 - STAGE_IDX * ITERS;
  always_comb begin
    o_rem = i_rem;
    o_quot = i_quot;
    for (int j = 0; j < ITERS; j++) begin
      o_rem = {o_rem[WIDTH-1:0], i_bits[ITERS-1-j]};
      o_quot[MSB-j] = o_rem >= {1'b0, i_divisor};
      o_rem = o_quot[MSB-j] ? o_rem - {1'b0, i_divisor} : o_rem;
    end
  end
endmodule

// File: rtl/pipelined_divider_valrdy.sv
// pipelined_divider_valrdy: STAGES-deep restoring divider with valid/ready, signed mode, div-by-zero flag and tag
module pipelined_divider_valrdy
  import divider_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STAGES = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  input  logic             in_signed,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             out_div_by_zero,
  output logic [TAG_W-1:0] out_tag
);
  localparam int ITERS = div_iters(WIDTH, STAGES);
  if (WIDTH < 2 || STAGES < 1 || WIDTH % STAGES != 0) begin : g_bad_params
    $error("pipelined_divider_valrdy: WIDTH must be >= 2 and a multiple of STAGES");
  end
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quot;
    logic [WIDTH:0]   rem;
    div_flags_t       f;
    logic [WIDTH-1:0] orig;
    logic [TAG_W-1:0] tag;
  } payload_t;
  payload_t         r_p [STAGES];
  payload_t         w_pre;
  logic [WIDTH-1:0] w_q [STAGES];
  logic [WIDTH:0]   w_r [STAGES];
  logic             w_adv, w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_qf, w_rf;
  logic             r_o_valid, r_o_dz;
  logic [WIDTH-1:0] r_o_q, r_o_r;
  logic [TAG_W-1:0] r_o_tag;
  assign w_adv = !r_o_valid || out_ready;
  assign in_ready = w_adv && reset;
  always_comb begin
    w_a_neg = in_signed & in_dividend[WIDTH-1];
    w_b_neg = in_signed & in_divisor[WIDTH-1];
    w_pre.valid = in_valid;
    w_pre.dividend = w_a_neg ? -in_dividend : in_dividend;
    w_pre.divisor = w_b_neg ? -in_divisor : in_divisor;
    w_pre.quot = '0;
    w_pre.rem = '0;
    w_pre.f.neg_q = (w_a_neg ^ w_b_neg) & (in_divisor != '0);
    w_pre.f.neg_r = w_a_neg;
    w_pre.f.dz = in_divisor == '0;
    w_pre.orig = in_dividend;
    w_pre.tag = in_tag;
  end
  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    divider_stage #(.WIDTH(WIDTH), .ITERS(ITERS), .STAGE_IDX(i)) u_stage (
      .i_bits    (r_p[i].dividend[WIDTH-1-i*ITERS -: ITERS]),
      .i_divisor (r_p[i].divisor),
      .i_quot    (r_p[i].quot),
      .i_rem     (r_p[i].rem),
      .o_quot    (w_q[i]),
      .o_rem     (w_r[i])
    );
  end
  // Sign fix-up and the divide-by-zero override are folded into the output register load
  always_comb begin
    w_qf = r_p[STAGES-1].f.neg_q ? -w_q[STAGES-1] : w_q[STAGES-1];
    w_rf = r_p[STAGES-1].f.neg_r ? -w_r[STAGES-1][WIDTH-1:0] : w_r[STAGES-1][WIDTH-1:0];
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int j = 0; j < STAGES; j++) r_p[j].valid <= 1'b0;
      r_o_valid <= 1'b0;
      r_o_q <= '0;
      r_o_r <= '0;
      r_o_dz <= 1'b0;
      r_o_tag <= '0;
    end else if (w_adv) begin
      r_p[0] <= w_pre;
      for (int j = 1; j < STAGES; j++) begin
        r_p[j] <= r_p[j-1];
        r_p[j].quot <= w_q[j-1];
        r_p[j].rem <= w_r[j-1];
      end
      r_o_valid <= r_p[STAGES-1].valid;
      if (r_p[STAGES-1].valid) begin
        r_o_q <= r_p[STAGES-1].f.dz ? '1 : w_qf;
        r_o_r <= r_p[STAGES-1].f.dz ? r_p[STAGES-1].orig : w_rf;
        r_o_dz <= r_p[STAGES-1].f.dz;
        r_o_tag <= r_p[STAGES-1].tag;
      end
    end
  end
  assign out_valid = r_o_valid;
  assign out_quotient = r_o_q;
  assign out_remainder = r_o_r;
  assign out_div_by_zero = r_o_dz;
  assign out_tag = r_o_tag;
endmodule

// File: tb/tb_pipelined_divider_valrdy.sv
// tb_pipelined_divider_valrdy: table vectors and hand sequences checked through an in-order result scoreboard
module tb_pipelined_divider_valrdy;
  localparam int W = 32, S = 8, T = 4;
  logic clk = 0, reset = 0, in_valid = 0, in_signed = 0, out_ready = 1;
  logic [W-1:0] in_dividend = 0, in_divisor = 0;
  logic [T-1:0] in_tag = 0;
  logic in_ready, out_valid, out_div_by_zero;
  logic [W-1:0] out_quotient, out_remainder;
  logic [T-1:0] out_tag;
  always #5 clk = ~clk;
  pipelined_divider_valrdy #(.WIDTH(W), .STAGES(S), .TAG_W(T)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_dividend(in_dividend), .in_divisor(in_divisor), .in_signed(in_signed), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_quotient(out_quotient),
    .out_remainder(out_remainder), .out_div_by_zero(out_div_by_zero), .out_tag(out_tag)
  );
  typedef struct { logic [W-1:0] q, r; logic dz; logic [T-1:0] tag; } res_t;
  typedef struct { logic [W-1:0] a, b; logic s; logic [T-1:0] tag; logic [W-1:0] q, r; logic dz; } vec_t;
  res_t sb[$];
  int n_vec = 0, n_bad = 0;
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic [T-1:0] tag);
    res_t x;
    x.tag = tag;
    x.dz = (b == 0);
    if (b == 0) begin x.q = '1; x.r = a; end
    else if (!s) begin x.q = a / b; x.r = a % b; end
    else if (b == '1) begin x.q = -a; x.r = 0; end
    else begin x.q = $signed(a) / $signed(b); x.r = $signed(a) % $signed(b); end
    return x;
  endfunction
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic [T-1:0] tag,
                      input res_t e, output int waits);
    in_valid = 1; in_dividend = a; in_divisor = b; in_signed = s; in_tag = tag; waits = 0;
    @(negedge clk);
    while (!in_ready && waits < 100) begin waits++; @(negedge clk); end
    if (!in_ready) begin
      n_vec++; n_bad++;
      $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, expected 1", waits);
    end else sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 0;
  endtask
  task automatic latency(input string name);
    for (int k = 1; k <= S; k++) begin
      @(posedge clk); #1;
      chk(name, 32'(out_valid), 32'(k == S));
    end
  endtask
  task automatic drain(input string name);
    int c = 0;
    while (sb.size() != 0 && c < 100) begin @(posedge clk); c++; end
    #1;
    chk(name, 32'(sb.size()), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin : mon
    res_t e;
    if (reset && out_valid && out_ready) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_output: got q=%h r=%h tag=%h, expected no result", out_quotient, out_remainder, out_tag);
      end else begin
        e = sb.pop_front();
        if ({out_quotient, out_remainder, out_div_by_zero, out_tag} !== {e.q, e.r, e.dz, e.tag}) begin
          n_bad++;
          $display("FAIL result: got q=%h r=%h dz=%b tag=%h, expected q=%h r=%h dz=%b tag=%h",
                   out_quotient, out_remainder, out_div_by_zero, out_tag, e.q, e.r, e.dz, e.tag);
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    vec_t tv[10];
    res_t e, e0;
    int waits, ones;
    tv[0] = '{32'd100, 32'd7, 1'b0, 4'd3, 32'd14, 32'd2, 1'b0};
    tv[1] = '{-32'sd7, 32'd2, 1'b1, 4'd1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
    tv[2] = '{32'd7, -32'sd2, 1'b1, 4'd2, 32'hFFFFFFFD, 32'd1, 1'b0};
    tv[3] = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 4'd4, 32'h80000000, 32'd0, 1'b0};
    tv[4] = '{32'hDEADBEEF, 32'd0, 1'b0, 4'd5, 32'hFFFFFFFF, 32'hDEADBEEF, 1'b1};
    tv[5] = '{-32'sd5, 32'd0, 1'b1, 4'd6, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1};
    tv[6] = '{32'hFFFFFFFF, 32'd1, 1'b0, 4'd7, 32'hFFFFFFFF, 32'd0, 1'b0};
    tv[7] = '{32'd5, 32'd10, 1'b0, 4'd8, 32'd0, 32'd5, 1'b0};
    tv[8] = '{-32'sd100, -32'sd7, 1'b1, 4'd9, 32'd14, 32'hFFFFFFFE, 1'b0};
    tv[9] = '{32'hFFFFFFFF, 32'h80000000, 1'b0, 4'hA, 32'd1, 32'h7FFFFFFF, 1'b0};
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("ready_in_reset", 32'(in_ready), 0);
    reset = 1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_q", out_quotient, 0);
    chk("rst_r", out_remainder, 0);
    chk("rst_dz", 32'(out_div_by_zero), 0);
    chk("rst_tag", 32'(out_tag), 0);
    // single op latency
    send(tv[0].a, tv[0].b, tv[0].s, tv[0].tag, '{tv[0].q, tv[0].r, tv[0].dz, tv[0].tag}, waits);
    latency("latency_100_7");
    drain("drain_first");
    // table vectors streamed back to back
    for (int i = 0; i < 10; i++)
      send(tv[i].a, tv[i].b, tv[i].s, tv[i].tag, '{tv[i].q, tv[i].r, tv[i].dz, tv[i].tag}, waits);
    drain("drain_table");
    // back-to-back throughput
    for (int i = 0; i < 8; i++) begin
      e = model(32'(i * 1000), 32'(i + 1), 1'b0, 4'(i));
      send(32'(i * 1000), 32'(i + 1), 1'b0, 4'(i), e, waits);
      chk("b2b_stall", 32'(waits), 0);
    end
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk("b2b_valid_run", 32'(out_valid), 1);
    end
    drain("drain_b2b");
    // back-pressure: fill with out_ready low, hold, then release
    out_ready = 0;
    for (int i = 0; i < 8; i++) begin
      e = model(32'(i * 77 + 3), 32'(i + 3), 1'b1, 4'(i + 8));
      if (i == 0) e0 = e;
      send(32'(i * 77 + 3), 32'(i + 3), 1'b1, 4'(i + 8), e, waits);
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_hold_q", out_quotient, e0.q);
      chk("bp_hold_tag", 32'(out_tag), 32'(e0.tag));
    end
    out_ready = 1;
    drain("drain_bp");
    // random signed/unsigned ops
    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] a, b;
      logic s;
      a = $urandom;
      b = ($urandom_range(0, 9) == 0) ? 0 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom);
      s = 1'($urandom_range(0, 1));
      send(a, b, s, 4'(i), model(a, b, s, 4'(i)), waits);
    end
    drain("drain_random");
    // reset with four operations in flight
    for (int i = 0; i < 4; i++) send(32'(50 + i), 32'd3, 1'b0, 4'(i), model(32'(50 + i), 32'd3, 1'b0, 4'(i)), waits);
    reset = 0;
    @(negedge clk);
    chk("mid_rst_ready", 32'(in_ready), 0);
    @(posedge clk); #1;
    reset = 1;
    sb.delete();
    chk("mid_rst_valid", 32'(out_valid), 0);
    ones = 0;
    repeat (12) begin @(posedge clk); #1; ones += int'(out_valid); end
    chk("mid_rst_no_ghosts", 32'(ones), 0);
    send(32'd9, 32'd3, 1'b0, 4'hC, '{32'd3, 32'd0, 1'b0, 4'hC}, waits);
    latency("latency_after_reset");
    drain("drain_after_reset");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
